// File: rtl/atomrvcore_iccm_loader.sv
// atomrvcore_iccm_loader: boot byte-stream loader that assembles little-endian words into ICCM writes
module atomrvcore_iccm_loader #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] BASE_ADDR = '0,
  parameter int                   MAX_WORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_req_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 iccm_we_o,
  output logic [DATAWIDTH-1:0] iccm_addr_o,
  output logic [DATAWIDTH-1:0] iccm_wdata_o,
  output logic                 PCrst_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int KW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_e;
  state_e               state_q, state_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [DATAWIDTH-1:0] sh_q, sh_d, sh_in;
  logic [DATAWIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [KW-1:0]        k_q, k_d, n_q, n_d;
  logic                 ready_q, ready_d, we_q, we_d, done_q, done_d, err_q, err_d, pcrst_q, pcrst_d;
  logic                 accept;
  always_comb begin
    accept  = byte_valid_i & ready_q;
    sh_in   = {byte_i, sh_q[DATAWIDTH-1:8]};
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    n_d     = n_q;
    case (state_q)
      IDLE, DONE, ERR: if (load_req_i) begin
        state_d = HDR;
        bcnt_d  = '0;
        k_d     = '0;
        addr_d  = BASE_ADDR;
      end
      HDR: if (accept) begin
        sh_d   = sh_in;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          n_d     = KW'(sh_in);
          state_d = (sh_in == '0) ? DONE : (sh_in > DATAWIDTH'(MAX_WORDS)) ? ERR : DATA;
        end
      end
      DATA: if (accept) begin
        sh_d   = sh_in;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          wdata_d = sh_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        k_d     = k_q + KW'(1);
        addr_d  = addr_q + DATAWIDTH'(4);
        state_d = (k_d == n_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so they appear together with it
    ready_d = (state_d == HDR) || (state_d == DATA);
    we_d    = state_d == WRITE;
    done_d  = state_d == DONE;
    err_d   = state_d == ERR;
    pcrst_d = state_d != DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      k_q     <= '0;
      n_q     <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pcrst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pcrst_q <= pcrst_d;
    end
  end
  assign byte_ready_o = ready_q;
  assign iccm_we_o    = we_q;
  assign iccm_addr_o  = addr_q;
  assign iccm_wdata_o = wdata_q;
  assign PCrst_o      = pcrst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
// tb_atomrvcore_iccm_loader: directed bench; dut0 uses default parameters, dut1 has BASE_ADDR=0x100 and MAX_WORDS=2
module tb_atomrvcore_iccm_loader;
  logic clk = 1'b0, rst_ni = 1'b0, lr0 = 1'b0, lr1 = 1'b0, bv = 1'b0;
  logic [7:0] bi = '0;
  logic r0, we0, pc0, dn0, er0, r1, we1, pc1, dn1, er1;
  logic [31:0] a0, d0, a1, d1;
  logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];
  int checks = 0, errors = 0, cyc = 0, c0 = 0, sel = 0;

  atomrvcore_iccm_loader dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .load_req_i(lr0), .byte_i(bi), .byte_valid_i(bv),
    .byte_ready_o(r0), .iccm_we_o(we0), .iccm_addr_o(a0), .iccm_wdata_o(d0),
    .PCrst_o(pc0), .done_o(dn0), .err_o(er0));
  atomrvcore_iccm_loader #(.DATAWIDTH(32), .BASE_ADDR(32'h100), .MAX_WORDS(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .load_req_i(lr1), .byte_i(bi), .byte_valid_i(bv),
    .byte_ready_o(r1), .iccm_we_o(we1), .iccm_addr_o(a1), .iccm_wdata_o(d1),
    .PCrst_o(pc1), .done_o(dn1), .err_o(er1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (we0) begin qa0.push_back(a0); qd0.push_back(d0); end
    if (we1) begin qa1.push_back(a1); qd1.push_back(d1); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc, got;
    got = 1'b0;
    bi = b; bv = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      acc = sel ? r1 : r0;
      tick();
      got = acc;
    end
    chk("send_accepted", {31'd0, got}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      if (gap) begin bv = 1'b0; tick(); end
    end
  endtask

  task automatic req(input int which);
    if (which != 0) lr1 = 1'b1; else lr0 = 1'b1;
    tick();
    lr0 = 1'b0; lr1 = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      seen = sel ? dn1 : dn0;
      if (!seen) tick();
    end
    chk("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", {31'd0, r0}, 0);
    chk("rst_we", {31'd0, we0}, 0);
    chk("rst_pcrst", {31'd0, pc0}, 1);
    chk("rst_done", {31'd0, dn0}, 0);
    chk("rst_err", {31'd0, er0}, 0);
    chk("rst_addr", a0, 32'h0);
    chk("rst_wdata", d0, 32'h0);
    chk("rst_addr_base100", a1, 32'h100);
    rst_ni = 1'b1;
    tick();
    chk("idle_ready", {31'd0, r0}, 0);
    // two-word image, continuous valid
    req(0);
    chk("hdr_ready", {31'd0, r0}, 1);
    chk("hdr_pcrst", {31'd0, pc0}, 1);
    send_word(32'd2, 0);
    c0 = cyc;
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    bv = 1'b0;
    wait_done();
    chk("img1_cycles", cyc - c0, 10);
    chk("img1_nwrites", qa0.size(), 2);
    chk("img1_a0", qa0[0], 32'h0);
    chk("img1_d0", qd0[0], 32'h12345678);
    chk("img1_a1", qa0[1], 32'h4);
    chk("img1_d1", qd0[1], 32'hDEADBEEF);
    chk("img1_done", {31'd0, dn0}, 1);
    chk("img1_pcrst", {31'd0, pc0}, 0);
    chk("img1_ready", {31'd0, r0}, 0);
    qa0.delete(); qd0.delete();
    // same image, valid toggled every other cycle, restarted from DONE
    req(0);
    chk("reload_pcrst", {31'd0, pc0}, 1);
    chk("reload_done", {31'd0, dn0}, 0);
    send_word(32'd2, 1);
    send_word(32'h12345678, 1);
    send_word(32'hDEADBEEF, 1);
    wait_done();
    chk("img2_nwrites", qa0.size(), 2);
    chk("img2_a0", qa0[0], 32'h0);
    chk("img2_d0", qd0[0], 32'h12345678);
    chk("img2_a1", qa0[1], 32'h4);
    chk("img2_d1", qd0[1], 32'hDEADBEEF);
    qa0.delete(); qd0.delete();
    // empty image
    req(0);
    send_word(32'd0, 0);
    bv = 1'b0;
    chk("n0_done", {31'd0, dn0}, 1);
    chk("n0_pcrst", {31'd0, pc0}, 0);
    tick(); tick();
    chk("n0_nwrites", qa0.size(), 0);
    // oversized header
    req(0);
    send_word(32'h401, 0);
    bv = 1'b0;
    chk("big_err", {31'd0, er0}, 1);
    chk("big_pcrst", {31'd0, pc0}, 1);
    chk("big_ready", {31'd0, r0}, 0);
    chk("big_done", {31'd0, dn0}, 0);
    tick(); tick(); tick();
    chk("big_nwrites", qa0.size(), 0);
    chk("big_err_held", {31'd0, er0}, 1);
    req(0);
    chk("err_reload_err", {31'd0, er0}, 0);
    chk("err_reload_ready", {31'd0, r0}, 1);
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    bv = 1'b0;
    wait_done();
    chk("after_err_nwrites", qa0.size(), 1);
    chk("after_err_a", qa0[0], 32'h0);
    chk("after_err_d", qd0[0], 32'hCAFEF00D);
    qa0.delete(); qd0.delete();
    // asynchronous reset after two bytes of the first word
    req(0);
    send_word(32'd1, 0);
    send(8'h11);
    send(8'h22);
    bv = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", {31'd0, r0}, 0);
    chk("arst_we", {31'd0, we0}, 0);
    chk("arst_pcrst", {31'd0, pc0}, 1);
    chk("arst_done", {31'd0, dn0}, 0);
    chk("arst_err", {31'd0, er0}, 0);
    chk("arst_addr", a0, 32'h0);
    chk("arst_wdata", d0, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick(); tick();
    chk("arst_nwrites", qa0.size(), 0);
    chk("arst_idle_ready", {31'd0, r0}, 0);
    req(0);
    send_word(32'd1, 0);
    send_word(32'hA5A5A5A5, 0);
    bv = 1'b0;
    wait_done();
    chk("post_arst_nwrites", qa0.size(), 1);
    chk("post_arst_d", qd0[0], 32'hA5A5A5A5);
    qa0.delete(); qd0.delete();
    // offset base, reload from DONE, capacity boundary
    sel = 1;
    req(1);
    send_word(32'd1, 0);
    send_word(32'h0BADC0DE, 0);
    bv = 1'b0;
    wait_done();
    chk("b100_nwrites", qa1.size(), 1);
    chk("b100_a", qa1[0], 32'h100);
    chk("b100_d", qd1[0], 32'h0BADC0DE);
    chk("b100_pcrst", {31'd0, pc1}, 0);
    qa1.delete(); qd1.delete();
    req(1);
    chk("b100_reload_pcrst", {31'd0, pc1}, 1);
    chk("b100_reload_done", {31'd0, dn1}, 0);
    send_word(32'd2, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    bv = 1'b0;
    wait_done();
    chk("max_nwrites", qa1.size(), 2);
    chk("max_a0", qa1[0], 32'h100);
    chk("max_d0", qd1[0], 32'h11111111);
    chk("max_a1", qa1[1], 32'h104);
    chk("max_d1", qd1[1], 32'h22222222);
    qa1.delete(); qd1.delete();
    req(1);
    send_word(32'd3, 0);
    bv = 1'b0;
    chk("max1_err", {31'd0, er1}, 1);
    chk("max1_pcrst", {31'd0, pc1}, 1);
    tick();
    chk("max1_nwrites", qa1.size(), 0);
    chk("dut0_untouched", qa0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/atomrvcore_iccm_loader.md
# atomrvcore_iccm_loader

Boot-time program loader that writes the instruction memory (ICCM) which the fetch unit later reads. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues single-cycle ICCM writes at consecutive word addresses. It holds the core's PC reset asserted until the whole image is written. It sits between an external boot link (UART/JTAG shim) and the ICCM write port (`DATA_i`/`IWR_EN_i`/`address_i`).

## Interface
Parameters:
- `DATAWIDTH`, 32: ICCM word and address width.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, 1024: ICCM capacity in words; the largest accepted image.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `load_req_i` in 1: start or restart a load. Sampled only in IDLE, DONE and ERR.
- `byte_i` in 8: stream byte.
- `byte_valid_i` in 1: `byte_i` is valid.
- `byte_ready_o` out 1: loader accepts a byte this cycle.
- `iccm_we_o` out 1: ICCM write enable, one cycle per word.
- `iccm_addr_o` out DATAWIDTH: ICCM byte address.
- `iccm_wdata_o` out DATAWIDTH: ICCM write data.
- `PCrst_o` out 1: PC/core reset, active-high; high while not DONE.
- `done_o` out 1: image fully written.
- `err_o` out 1: header rejected.

## Operation
- Stream format: 4-byte little-endian header N (word count), then N words, each 4 bytes little-endian (first byte goes to bits [7:0]).
- Byte accepted iff `byte_valid_i & byte_ready_o` at a rising edge.
- States:
  - IDLE: `load_req_i` moves to HDR; clears byte counter, word counter and address.
  - HDR: `byte_ready_o`=1. After the 4th accepted byte: N==0 goes to DONE; N>MAX_WORDS goes to ERR; otherwise goes to DATA.
  - DATA: `byte_ready_o`=1. The 4th accepted byte of a word goes to WRITE.
  - WRITE: one cycle.
    - Outputs: `byte_ready_o`=0, `iccm_we_o`=1, `iccm_addr_o`=BASE_ADDR+4*k, `iccm_wdata_o`=assembled word.
    - Next state: k+1==N goes to DONE; otherwise returns to DATA.
    - On exit: k increments and the address advances by 4.
  - DONE: `done_o`=1, `PCrst_o`=0. `load_req_i` goes to HDR and re-asserts `PCrst_o` in that same cycle's registered output.
  - ERR: `err_o`=1, `PCrst_o`=1. `load_req_i` goes to HDR.
- Header compare uses the full 32 bits of N.
- Word counter width is clog2(MAX_WORDS+1). Address arithmetic is DATAWIDTH bits, modulo 2^DATAWIDTH.
- `load_req_i` during HDR/DATA/WRITE is ignored. An in-progress load cannot be aborted except by `rst_ni`.
- Bytes presented while `byte_ready_o`=0 are not consumed; the source must hold them.
- All outputs are registered or decoded from state only; no combinational path from `byte_valid_i` to `byte_ready_o`.

## Timing
- Reset values:
  - State = IDLE.
  - `PCrst_o`=1.
  - `byte_ready_o`, `iccm_we_o`, `done_o`, `err_o` = 0.
  - `iccm_addr_o`=BASE_ADDR.
  - `iccm_wdata_o`=0.
- Reset is asynchronous: asserting `rst_ni` mid-load immediately forces the reset values, and any partial word is discarded.
- Latency: the WRITE cycle directly follows the edge that accepts a word's 4th byte. With continuous valid, each word costs 5 cycles (4 accept + 1 write).
- DONE is entered on the edge ending the last WRITE. `PCrst_o` falls and `done_o` rises in the following cycle.
- N==0: `done_o` asserts the cycle after the 4th header byte; no ICCM writes occur.
- N==MAX_WORDS is accepted. The last write goes to BASE_ADDR+4*(MAX_WORDS-1).
- `iccm_addr_o`/`iccm_wdata_o` are stable throughout the WRITE cycle. They are don't-care when `iccm_we_o`=0.

## Test plan
- Reset then `load_req_i`. Stream header 02 00 00 00, then 78 56 34 12, then EF BE AD DE, with continuous valid.
  - Writes 0x12345678@0x0 and 0xDEADBEEF@0x4.
  - `done_o`=1, `PCrst_o`=0.
  - Total 8+2 data-phase cycles after the header.
- Same image with `byte_valid_i` toggled every other cycle: identical writes, and no byte is lost or duplicated while `byte_ready_o`=0 during WRITE.
- Header 00 00 00 00: goes straight to DONE, zero `iccm_we_o` pulses.
- Header with N=MAX_WORDS+1 (0x401): `err_o`=1, `PCrst_o` stays 1, `byte_ready_o`=0, no writes. A following `load_req_i` and a valid 1-word image complete with `done_o`=1.
- Drop `rst_ni` after 2 bytes of word 1: all outputs return to reset values asynchronously, and no write of the partial word occurs.
- Second `load_req_i` in DONE with BASE_ADDR=0x100: `PCrst_o` re-asserts and `done_o` falls. A 1-word image writes to 0x100.
